morse_encoder: RTL and testbench

- Converts a stream of ASCII bytes into a keyed Morse output (`key`) with standard unit timing.
- Drives an LED, buzzer or transmitter enable.
- Counterpart to the team's Morse decoding path: that path turns key presses into ASCII; this block turns ASCII (e.g. from the UART receiver FIFO) into key timing.
- Symbol encoding matches the decoder's {count[2:0], pattern[4:0]} format: pattern bit 1 = dash, 0 = dot; the first symbol sent is pattern[count-1] and the last is pattern[0].

---
 rtl/morse_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_morse_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// morse_encoder
//   Turns accepted ASCII bytes into Morse keying with standard unit timing:
//   dot = 1 unit mark, dash = 3 units, 1 unit between symbols, 3 units after
//   each character, and a space adds 4 more units (7 total word gap).
//   One unit lasts UNIT_FINAL_VALUE+1 clock cycles.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   din        ASCII byte to send
//   wr_en      write strobe; byte accepted on an edge where wr_en & ready
//   ready      block can accept a byte (high only in IDLE)
//   busy       ~ready
//   key        registered keying output, high = mark
//   bad_char   one-cycle pulse after an unsupported byte was accepted/dropped
//   char_done  one-cycle pulse in the cycle ready re-asserts after a character
//              or space completes
module morse_encoder #(
  parameter int UNIT_FINAL_VALUE = 9_999_999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       ready,
  output logic       busy,
  output logic       key,
  output logic       bad_char,
  output logic       char_done
);

  localparam int TW = (UNIT_FINAL_VALUE > 0) ? $clog2(UNIT_FINAL_VALUE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SYMGAP,
    GAP
  } state_t;

  // Symbol code {count[2:0], pattern[4:0]}; count 0 marks an unsupported byte.
  // pattern bit 1 = dash, sent from pattern[count-1] down to pattern[0].
  function automatic logic [7:0] char_code(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] code;
    // Case-fold lower-case letters onto upper-case.
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    case (u)
      8'h41: code = {3'd2, 5'b00001}; // A .-
      8'h42: code = {3'd4, 5'b01000}; // B -...
      8'h43: code = {3'd4, 5'b01010}; // C -.-.
      8'h44: code = {3'd3, 5'b00100}; // D -..
      8'h45: code = {3'd1, 5'b00000}; // E .
      8'h46: code = {3'd4, 5'b00010}; // F ..-.
      8'h47: code = {3'd3, 5'b00110}; // G --.
      8'h48: code = {3'd4, 5'b00000}; // H ....
      8'h49: code = {3'd2, 5'b00000}; // I ..
      8'h4A: code = {3'd4, 5'b00111}; // J .---
      8'h4B: code = {3'd3, 5'b00101}; // K -.-
      8'h4C: code = {3'd4, 5'b00100}; // L .-..
      8'h4D: code = {3'd2, 5'b00011}; // M --
      8'h4E: code = {3'd2, 5'b00010}; // N -.
      8'h4F: code = {3'd3, 5'b00111}; // O ---
      8'h50: code = {3'd4, 5'b00110}; // P .--.
      8'h51: code = {3'd4, 5'b01101}; // Q --.-
      8'h52: code = {3'd3, 5'b00010}; // R .-.
      8'h53: code = {3'd3, 5'b00000}; // S ...
      8'h54: code = {3'd1, 5'b00001}; // T -
      8'h55: code = {3'd3, 5'b00001}; // U ..-
      8'h56: code = {3'd4, 5'b00001}; // V ...-
      8'h57: code = {3'd3, 5'b00011}; // W .--
      8'h58: code = {3'd4, 5'b01001}; // X -..-
      8'h59: code = {3'd4, 5'b01011}; // Y -.--
      8'h5A: code = {3'd4, 5'b01100}; // Z --..
      8'h30: code = {3'd5, 5'b11111}; // 0
      8'h31: code = {3'd5, 5'b01111}; // 1
      8'h32: code = {3'd5, 5'b00111}; // 2
      8'h33: code = {3'd5, 5'b00011}; // 3
      8'h34: code = {3'd5, 5'b00001}; // 4
      8'h35: code = {3'd5, 5'b00000}; // 5
      8'h36: code = {3'd5, 5'b10000}; // 6
      8'h37: code = {3'd5, 5'b11000}; // 7
      8'h38: code = {3'd5, 5'b11100}; // 8
      8'h39: code = {3'd5, 5'b11110}; // 9
      default: code = 8'h00;
    endcase
    char_code = code;
  endfunction

  // Mark length in units for the symbol at pattern[idx].
  function automatic logic [2:0] mark_units(input logic [4:0] pat, input logic [2:0] idx);
    mark_units = pat[idx] ? 3'd3 : 3'd1;
  endfunction

  state_t       state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]   units_q;
  logic [2:0]   count_q;
  logic [4:0]   pattern_q;
  logic         key_q;
  logic         ready_q;
  logic         bad_char_q;
  logic         char_done_q;

  logic [7:0]   code_d;
  logic [2:0]   count_d;
  logic [4:0]   pattern_d;
  logic         space_d;
  logic         tick;
  logic         last_unit;

  assign code_d    = char_code(din);
  assign count_d   = code_d[7:5];
  assign pattern_d = code_d[4:0];
  assign space_d   = (din == 8'h20);

  assign tick      = (timer_q == TW'(UNIT_FINAL_VALUE));
  // A period ends on the tick of its final unit.
  assign last_unit = tick && (units_q == 3'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      units_q     <= '0;
      count_q     <= '0;
      pattern_q   <= '0;
      key_q       <= 1'b0;
      ready_q     <= 1'b1;
      bad_char_q  <= 1'b0;
      char_done_q <= 1'b0;
    end else begin
      bad_char_q  <= 1'b0;
      char_done_q <= 1'b0;

      // Every state entry happens either from IDLE or on a tick, so this
      // also restarts the timer at the start of each period.
      if ((state_q == IDLE) || tick) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end

      if ((state_q != IDLE) && tick && !last_unit) begin
        units_q <= units_q - 3'd1;
      end

      case (state_q)
        IDLE: begin
          if (wr_en) begin
            if (space_d) begin
              state_q <= GAP;
              units_q <= 3'd4;
              ready_q <= 1'b0;
            end else if (count_d != 3'd0) begin
              state_q   <= MARK;
              count_q   <= count_d;
              pattern_q <= pattern_d;
              units_q   <= mark_units(pattern_d, count_d - 3'd1);
              key_q     <= 1'b1;
              ready_q   <= 1'b0;
            end else begin
              bad_char_q <= 1'b1;
            end
          end
        end

        MARK: begin
          if (last_unit) begin
            key_q   <= 1'b0;
            count_q <= count_q - 3'd1;
            if (count_q == 3'd1) begin
              state_q <= GAP;
              units_q <= 3'd3;
            end else begin
              state_q <= SYMGAP;
              units_q <= 3'd1;
            end
          end
        end

        SYMGAP: begin
          if (last_unit) begin
            state_q <= MARK;
            key_q   <= 1'b1;
            units_q <= mark_units(pattern_q, count_q - 3'd1);
          end
        end

        GAP: begin
          if (last_unit) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            char_done_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          key_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = ~ready_q;
  assign key       = key_q;
  assign bad_char  = bad_char_q;
  assign char_done = char_done_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Testbench for morse_encoder with UNIT_FINAL_VALUE=3 (4 cycles per unit).
// Expected key waveforms come from a dot/dash string table and unit rules.
module tb_morse_encoder;

  localparam int UFV = 3;
  localparam int N   = UFV + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       ready, busy, key, bad_char, char_done;

  int checks = 0;
  int errors = 0;
  int lowbusy, first_hi, last_hi, dones;

  typedef logic bitq_t[$];

  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};
  logic [7:0] unsupported[10] = '{8'h00, 8'h21, 8'h23, 8'h2F, 8'h3A,
                                  8'h40, 8'h5B, 8'h60, 8'h7B, 8'hFF};

  always #5 clk = ~clk;

  morse_encoder #(.UNIT_FINAL_VALUE(UFV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (din),
    .wr_en    (wr_en),
    .ready    (ready),
    .busy     (busy),
    .key      (key),
    .bad_char (bad_char),
    .char_done(char_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic string morse_of(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return letters[int'(c) - 65];
    if (c >= 8'h61 && c <= 8'h7A) return letters[int'(c) - 97];
    if (c >= 8'h30 && c <= 8'h39) return digits[int'(c) - 48];
    return "";
  endfunction

  // Per-cycle key level from acceptance until ready returns.
  function automatic bitq_t expected_key(input logic [7:0] c);
    bitq_t q;
    string m;
    q = {};
    if (c == 8'h20) begin
      for (int k = 0; k < 4 * N; k++) q.push_back(1'b0);
      return q;
    end
    m = morse_of(c);
    for (int s = 0; s < m.len(); s++) begin
      int len;
      len = (m[s] == "-") ? 3 * N : N;
      for (int k = 0; k < len; k++) q.push_back(1'b1);
      if (s != m.len() - 1)
        for (int k = 0; k < N; k++) q.push_back(1'b0);
    end
    for (int k = 0; k < 3 * N; k++) q.push_back(1'b0);
    return q;
  endfunction

  // Called at a negedge with ready expected high; returns at the negedge of
  // the cycle in which ready is back. pulse_at >= 0 pulses wr_en mid-char.
  task automatic send_char(input logic [7:0] c, input int pulse_at, input string tag);
    bitq_t exp;
    exp = expected_key(c);
    check({tag, "_ready_before"}, ready, 1);
    din = c;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    first_hi = -1;
    last_hi = -1;
    lowbusy = 0;
    for (int i = 0; i < exp.size(); i++) begin
      if (i == pulse_at) begin
        din = 8'h58;
        wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
        din = 8'($urandom);
      end
      check({tag, "_key"}, key, exp[i]);
      check({tag, "_ready"}, ready, 0);
      check({tag, "_char_done_mid"}, char_done, 0);
      check({tag, "_bad_char_mid"}, bad_char, 0);
      if (key === 1'b1) begin
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
      if (key === 1'b0 && busy === 1'b1) lowbusy++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check({tag, "_ready_end"}, ready, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_key_end"}, key, 0);
    check({tag, "_char_done"}, char_done, 1);
    if (char_done === 1'b1) dones++;
  endtask

  task automatic send_bad(input logic [7:0] c, input string tag);
    check({tag, "_ready_before"}, ready, 1);
    din = c;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check({tag, "_bad_char"}, bad_char, 1);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_key"}, key, 0);
  endtask

  initial begin
    logic [7:0] c;
    int r;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key", key, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bad_char", bad_char, 0);
    check("rst_char_done", char_done, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", ready, 1);

    // 'A': dot, symbol gap, dash, character gap; ready back at E+33
    send_char(8'h41, -1, "A");
    check("A_first_hi", first_hi, 0);
    check("A_last_hi", last_hi, 19);

    // 'e' then '0' back-to-back
    send_char(8'h65, -1, "e");
    check("e_mark_len", last_hi - first_hi + 1, 4);
    check("e_gap_len", lowbusy, 12);
    send_char(8'h30, -1, "zero");
    check("zero_mark_span", last_hi - first_hi + 1, 76);

    // 'T', space, 'T': 7 units low between the marks, three completions
    dones = 0;
    send_char(8'h54, -1, "T1");
    r = lowbusy;
    send_char(8'h20, -1, "space");
    check("word_gap_low", r + lowbusy, 28);
    send_char(8'h54, -1, "T2");
    check("tst_char_done_count", dones, 3);

    // Unsupported byte, then 'E' on the very next cycle
    send_bad(8'h23, "hash");
    send_char(8'h45, -1, "E_after_hash");

    // wr_en pulsed mid-'5' is ignored; no extra character follows
    send_char(8'h35, 10, "five");
    repeat (6) begin
      check("five_no_extra_ready", ready, 1);
      check("five_no_extra_key", key, 0);
      @(negedge clk);
    end

    // Reset during the dash of 'K'
    din = 8'h4B;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    check("K_in_dash", key, 1);
    reset_n = 1'b0;
    #1;
    check("K_rst_key", key, 0);
    check("K_rst_ready", ready, 1);
    check("K_rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_char(8'h45, -1, "E_after_rst");

    // Randomized character stream
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) c = 8'(8'h41 + $urandom_range(0, 25));
      else if (r <= 5) c = 8'(8'h61 + $urandom_range(0, 25));
      else if (r <= 7) c = 8'(8'h30 + $urandom_range(0, 9));
      else if (r == 8) c = 8'h20;
      else c = unsupported[$urandom_range(0, 9)];
      if (r == 9) begin
        send_bad(c, "rnd_bad");
        @(negedge clk);
        check("rnd_bad_clear", bad_char, 0);
      end else begin
        send_char(c, (r == 4) ? int'($urandom_range(0, 20)) : -1, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
